// File: rtl/adder_share_arbiter.sv
// Shares one 3-bit adder between two requesters: round-robin grant, per-requester carry chaining.
// Latency: acceptance to response valid is ADD_LAT+2 cycles; best case one op per ADD_LAT+4 cycles.
// Backpressure: response held until the granted requester takes it; no request accepted meanwhile.
module adder_share_arbiter #(
    parameter int ADD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [2:0] req0_a,
    input  logic [2:0] req1_a,
    input  logic [2:0] req0_b,
    input  logic [2:0] req1_b,
    input  logic       req0_cin,
    input  logic       req1_cin,
    input  logic       req0_chain,
    input  logic       req1_chain,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    input  logic       rsp0_ready,
    input  logic       rsp1_ready,
    output logic [2:0] rsp_sum,
    output logic       rsp_cout,
    output logic [2:0] add_a,
    output logic [2:0] add_b,
    output logic       add_cin,
    input  logic [2:0] add_sum,
    input  logic       add_cout,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] LP_LAT = 2'(ADD_LAT);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_cnt;
    logic       r_holdoff;
    logic       r_last_grant;
    logic       r_grant_id;
    logic [1:0] r_carry_q;
    logic [2:0] r_op_a;
    logic [2:0] r_op_b;
    logic       r_op_cin;
    logic [2:0] r_res_sum;
    logic       r_res_cout;

    logic       w_can_accept;
    logic       w_sel;
    logic       w_accept;
    logic       w_rsp_take;
    logic       w_eff_cin;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)        w_next_state = ST_WAIT;
            ST_WAIT: if (r_cnt == 2'd0)   w_next_state = ST_RESP;
            ST_RESP: if (w_rsp_take)      w_next_state = ST_IDLE;
            default:                      w_next_state = ST_IDLE;
        endcase
    end

    // Output logic; r_holdoff keeps the first IDLE cycle after a response closed to requests
    always_comb begin
        w_can_accept = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: w_can_accept = !r_holdoff && !rst;
            ST_WAIT: busy = 1'b1;
            ST_RESP: begin
                busy       = 1'b1;
                rsp0_valid = !r_grant_id && !rst;
                rsp1_valid = r_grant_id && !rst;
            end
            default: busy = 1'b0;
        endcase
    end

    assign w_sel      = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign req0_ready = w_can_accept && req0_valid && !w_sel;
    assign req1_ready = w_can_accept && req1_valid && w_sel;
    assign w_accept   = req0_ready || req1_ready;
    assign w_rsp_take = (r_state == ST_RESP) && (r_grant_id ? rsp1_ready : rsp0_ready);
    assign w_eff_cin  = w_sel ? (req1_chain ? r_carry_q[1] : req1_cin)
                              : (req0_chain ? r_carry_q[0] : req0_cin);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 2'd0;
            r_holdoff    <= 1'b0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_carry_q    <= 2'b00;
            r_op_a       <= 3'd0;
            r_op_b       <= 3'd0;
            r_op_cin     <= 1'b0;
            r_res_sum    <= 3'd0;
            r_res_cout   <= 1'b0;
        end else begin
            r_holdoff <= w_rsp_take;
            if (w_accept) begin
                r_op_a       <= w_sel ? req1_a : req0_a;
                r_op_b       <= w_sel ? req1_b : req0_b;
                r_op_cin     <= w_eff_cin;
                r_grant_id   <= w_sel;
                r_last_grant <= w_sel;
                r_cnt        <= LP_LAT;
            end
            if (r_state == ST_WAIT) begin
                if (r_cnt == 2'd0) begin
                    r_res_sum  <= add_sum;
                    r_res_cout <= add_cout;
                end else begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
            if (w_rsp_take) begin
                r_carry_q[r_grant_id] <= r_res_cout;
            end
        end
    end

    assign add_a    = r_op_a;
    assign add_b    = r_op_b;
    assign add_cin  = r_op_cin;
    assign rsp_sum  = r_res_sum;
    assign rsp_cout = r_res_cout;
    assign grant_id = r_grant_id;

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares a single `tt_um_parallel_adder` instance between two requesters. Each requester issues 3-bit add operations over a valid/ready handshake and receives sum/carry on its own response channel. A per-requester carry register supports chained multi-word addition. The block sits between the requesters and the adder and owns the adder's operand inputs.

## Interface
- `ADD_LAT`, default 1: adder result latency in cycles after operands are stable; legal range 0..3.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when valid&ready.
- `req0_a`, `req1_a`  in  3  operand A.
- `req0_b`, `req1_b`  in  3  operand B.
- `req0_cin`, `req1_cin`  in  1  carry-in, used when chain=0.
- `req0_chain`, `req1_chain`  in  1  when 1, use that requester's stored carry instead of `reqN_cin`.
- `rsp0_valid`, `rsp1_valid`  out  1  result present, held until taken.
- `rsp0_ready`, `rsp1_ready`  in  1  requester takes the result.
- `rsp_sum`  out  3  result sum, shared by both response channels.
- `rsp_cout`  out  1  result carry, shared by both response channels.
- `add_a`, `add_b`  out  3  operands to the adder.
- `add_cin`  out  1  carry-in to the adder.
- `add_sum`  in  3  sum from the adder.
- `add_cout`  in  1  carry-out from the adder.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  1  requester that owns the current operation.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - The selected requester gets `ready` combinationally from the valids.
  - Selection when only one requester is valid: that requester.
  - Selection when both are valid: the requester that is not `last_grant`.
  - The non-selected requester's `ready` is 0.
- Acceptance (valid&ready):
  - Latch a, b, and the effective cin into operand registers.
  - Effective cin = `carry_q[N]` if `reqN_chain` is 1, else `reqN_cin`.
  - Set `grant_id` = N and `last_grant` = N.
  - Load wait counter with ADD_LAT.
  - Go to WAIT.
- `add_a`, `add_b`, `add_cin` are always driven from the operand registers, so they are stable from the cycle after acceptance until the next acceptance.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter equals 0, capture `add_sum` and `add_cout` into result registers, then go to RESP.
- RESP:
  - `rspN_valid` = 1 only for N = `grant_id`.
  - On `rspN_ready`: write `carry_q[N]` with the captured cout, drop valid, and go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- No request is accepted in the cycle the response is taken. IDLE lasts at least one cycle.
- `carry_q[0]` and `carry_q[1]` are independent. A non-chained request still updates `carry_q` on completion.
- Arithmetic: 3-bit + 3-bit + cin yields `{cout, sum}` = a+b+cin, range 0..15. Correctness comes from the adder; the block passes the result through unmodified.

## Timing
- Reset values:
  - State IDLE.
  - `rsp*_valid` = 0, `req*_ready` = 0 while `rst` is high.
  - `add_a` = `add_b` = 0, `add_cin` = 0.
  - `rsp_sum` = 0, `rsp_cout` = 0.
  - `busy` = 0, `grant_id` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - `carry_q` = 2'b00.
- Acceptance in cycle T:
  - Operands appear on `add_*` in cycle T+1.
  - Result is captured at the end of cycle T+1+ADD_LAT.
  - `rsp_valid` is high from cycle T+2+ADD_LAT.
  - With ADD_LAT=1, `rsp_valid` is high from cycle T+3.
- Peak throughput: one operation per ADD_LAT+4 cycles when `rsp_ready` is held high.
- A requester may drop `valid` while not granted; it loses nothing.
- Reset mid-operation (WAIT or RESP):
  - Next cycle is IDLE with all outputs at reset values.
  - The in-flight result is discarded.
  - `carry_q` is cleared.
- Simultaneous valid in IDLE: grant strictly alternates.

## Test plan
- Single op, ADD_LAT=1: req0 a=3, b=4, cin=1 accepted at T.
  - Required: `add_*` = 3/4/1 at T+1.
  - Required: `rsp0_valid` at T+3 with sum=0, cout=1 (3+4+1 = 8).
  - Required: `rsp1_valid` stays 0.
- Tie after reset: both valid with held requests.
  - Required: grants go 0, 1, 0, 1.
  - Required: each `rsp` appears only on the granted channel.
  - Required: the non-granted `ready` is 0 in every IDLE cycle.
- Chain: req1 a=7, b=1, cin=0 gives sum=0, cout=1. Then req1 a=0, b=0, chain=1.
  - Required: second result sum=1, cout=0.
  - Required: `carry_q[0]` unaffected; a chained req0 uses cin=0.
- Backpressure: hold `rsp0_ready`=0 for 5 cycles.
  - Required: `rsp0_valid`, `rsp_sum`, `rsp_cout` stable.
  - Required: `req1_ready` stays 0 throughout.
  - Required: after the response is taken, IDLE lasts one cycle, then req1 is accepted.
- Reset in WAIT: assert `rst` one cycle after acceptance.
  - Required: no `rsp_valid` appears.
  - Required: `carry_q` = 0.
  - Required: first post-reset tie goes to requester 0.
- ADD_LAT=0 and ADD_LAT=3 builds: measure acceptance-to-`rsp_valid` latency.
  - Required: exactly 2 and 5 cycles respectively.
  - Required: exhaustive a, b, cin sweep (128 ops) matches a+b+cin.
